// File: rtl/instruction_fetch_cache.sv
// ----------------------------------------------------------------------------
// instruction_fetch_cache
// A direct-mapped, read-only instruction cache with 16-byte lines. It sits
// between the fetch stage and instruction memory. A hit returns the 32-bit
// word in the same cycle. A miss stalls fetch and presents the line address to
// memory. After the memory latency has elapsed it captures the line, writes it
// into the cache, and the held request then hits.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          asynchronous, active-high reset
//   pc_addr      fetch byte address (bits [1:0] ignored)
//   pc_req       fetch request valid
//   flush        invalidate every line and abort any fill in progress
//   instr        fetched instruction word
//   instr_valid  instr is valid this cycle
//   stall        fetch must hold pc_addr / pc_req
//   mem_addr     16-byte aligned line address to instruction memory
//   mem_line     128-bit line data returned by instruction memory
//   miss_count   number of misses since reset, wraps at 16'hFFFF
// ----------------------------------------------------------------------------
module instruction_fetch_cache #(
  parameter int NUM_LINES   = 8,
  parameter int MEM_LATENCY = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  pc_addr,
  input  logic         pc_req,
  input  logic         flush,
  output logic [31:0]  instr,
  output logic         instr_valid,
  output logic         stall,
  output logic [31:0]  mem_addr,
  input  logic [127:0] mem_line,
  output logic [15:0]  miss_count
);

  localparam int IW = $clog2(NUM_LINES);
  localparam int TW = 28 - IW;
  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FILL  = 2'd2
  } state_t;

  state_t         state_r;
  state_t         state_nx_s;
  logic [CW-1:0]  cnt_r;
  logic [NUM_LINES-1:0] valid_r;
  logic [127:0]   data_r [NUM_LINES];
  logic [TW-1:0]  tag_r  [NUM_LINES];
  logic [IW-1:0]  miss_idx_r;
  logic [TW-1:0]  miss_tag_r;

  logic [1:0]     off_s;
  logic [IW-1:0]  idx_s;
  logic [TW-1:0]  tag_s;
  logic [127:0]   line_s;
  logic [31:0]    word_s;
  logic           hit_s;
  logic           start_miss_s;
  logic           fill_s;
  logic           unused_addr_bits_s;

  assign off_s  = pc_addr[3:2];
  assign idx_s  = pc_addr[4+IW-1:4];
  assign tag_s  = pc_addr[31:4+IW];
  assign line_s = data_r[idx_s];
  assign hit_s  = pc_req && valid_r[idx_s] && (tag_r[idx_s] == tag_s);
  assign unused_addr_bits_s = ^pc_addr[1:0];

  // Select the addressed 32-bit word out of the indexed line
  always_comb begin
    word_s = line_s[31:0];
    case (off_s)
      2'd0:    word_s = line_s[31:0];
      2'd1:    word_s = line_s[63:32];
      2'd2:    word_s = line_s[95:64];
      2'd3:    word_s = line_s[127:96];
      default: word_s = line_s[31:0];
    endcase
  end

  // Next-state and fetch-side outputs. Outputs are held at their reset values
  // while rst is high, so an asynchronous reset takes effect without a clock
  // edge. flush has priority in every state.
  always_comb begin
    state_nx_s   = state_r;
    instr        = 32'd0;
    instr_valid  = 1'b0;
    stall        = 1'b0;
    start_miss_s = 1'b0;
    fill_s       = 1'b0;
    if (rst) begin
      state_nx_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (flush) begin
            stall      = 1'b1;
            state_nx_s = IDLE;
          end else if (hit_s) begin
            instr       = word_s;
            instr_valid = 1'b1;
          end else if (pc_req) begin
            stall        = 1'b1;
            start_miss_s = 1'b1;
            state_nx_s   = FETCH;
          end else begin
            state_nx_s = IDLE;
          end
        end
        FETCH: begin
          stall = 1'b1;
          if (flush) begin
            state_nx_s = IDLE;
          end else if (cnt_r == CW'(MEM_LATENCY - 1)) begin
            state_nx_s = FILL;
          end else begin
            state_nx_s = FETCH;
          end
        end
        FILL: begin
          stall      = 1'b1;
          state_nx_s = IDLE;
          if (flush) begin
            fill_s = 1'b0;
          end else begin
            fill_s = 1'b1;
          end
        end
        default: begin
          state_nx_s = IDLE;
        end
      endcase
    end
  end

  // Control state: FSM, latency counter, valid bits, miss bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      valid_r    <= '0;
      mem_addr   <= 32'd0;
      miss_count <= 16'd0;
      miss_idx_r <= '0;
      miss_tag_r <= '0;
    end else begin
      state_r <= state_nx_s;
      if (flush) begin
        valid_r <= '0;
      end else if (fill_s) begin
        valid_r[miss_idx_r] <= 1'b1;
      end else begin
        valid_r <= valid_r;
      end
      // mem_addr only moves on entry to FETCH; any other change would restart memory
      if (start_miss_s) begin
        mem_addr   <= {pc_addr[31:4], 4'b0000};
        miss_idx_r <= idx_s;
        miss_tag_r <= tag_s;
        cnt_r      <= '0;
        miss_count <= miss_count + 16'd1;
      end else if (state_r == FETCH) begin
        cnt_r <= cnt_r + CW'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Line data and tag storage; no reset needed because valid_r gates every use
  always_ff @(posedge clk) begin
    if (fill_s) begin
      data_r[miss_idx_r] <= mem_line;
      tag_r[miss_idx_r]  <= miss_tag_r;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_cache.sv
// ----------------------------------------------------------------------------
// Bench for instruction_fetch_cache. A word-array instruction memory loads its
// output on the 5th edge after mem_addr changes. The expected values come from
// a simple model of the cache contents: which line address each index holds,
// plus the miss total.
// ----------------------------------------------------------------------------
module tb_instruction_fetch_cache;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  pc_addr;
  logic         pc_req;
  logic         flush;
  logic [31:0]  instr;
  logic         instr_valid;
  logic         stall;
  logic [31:0]  mem_addr;
  logic [127:0] mem_line;
  logic [15:0]  miss_count;

  instruction_fetch_cache #(.NUM_LINES(8), .MEM_LATENCY(6)) dut (
    .clk(clk), .rst(rst), .pc_addr(pc_addr), .pc_req(pc_req), .flush(flush),
    .instr(instr), .instr_valid(instr_valid), .stall(stall),
    .mem_addr(mem_addr), .mem_line(mem_line), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  // Instruction memory: 256 words, aliased over the upper address bits
  logic [31:0] mem [0:255];
  logic [31:0] a1 = 32'd0, a2 = 32'd0, a3 = 32'd0, a4 = 32'd0;

  function automatic logic [127:0] line_of(input logic [31:0] a);
    int w;
    w = int'({a[9:4], 2'b00});
    return {mem[w+3], mem[w+2], mem[w+1], mem[w]};
  endfunction

  always @(posedge clk) begin
    a1 <= mem_addr;
    a2 <= a1;
    a3 <= a2;
    a4 <= a3;
    mem_line <= line_of(a4);
  end

  // Reference model: the line address held by each index
  logic [27:0] mdl_line [8];
  bit          mdl_valid [8];
  int          mdl_mc;
  logic [31:0] mdl_maddr;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic mdl_clear();
    for (int i = 0; i < 8; i++) mdl_valid[i] = 1'b0;
  endtask

  // Returns the expected number of stall cycles for a request and updates the model
  task automatic mdl_access(input logic [31:0] a, output int es);
    int idx;
    idx = int'(a[6:4]);
    if (mdl_valid[idx] && mdl_line[idx] == a[31:4]) begin
      es = 0;
    end else begin
      es = 8;
      mdl_valid[idx] = 1'b1;
      mdl_line[idx]  = a[31:4];
      mdl_mc++;
      mdl_maddr = {a[31:4], 4'b0000};
    end
  endtask

  // Count stalled cycles from the current negedge until the request is served
  task automatic wait_serve(output int n);
    n = 0;
    while (stall === 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_req(input logic [31:0] a, output int n);
    @(posedge clk);
    #1;
    pc_addr = a;
    pc_req  = 1'b1;
    flush   = 1'b0;
    @(negedge clk);
    wait_serve(n);
  endtask

  task automatic check_req(input string name, input logic [31:0] a);
    int n, es;
    run_req(a, n);
    mdl_access(a, es);
    chk({name, " stalls"}, n, es);
    chk({name, " valid"}, {31'd0, instr_valid}, 32'd1);
    chk({name, " instr"}, instr, mem[a[9:2]]);
    chk({name, " miss_count"}, {16'd0, miss_count}, mdl_mc & 32'hFFFF);
    chk({name, " mem_addr"}, mem_addr, mdl_maddr);
  endtask

  typedef struct {
    logic [31:0] addr;
    int          exp_stalls;
    logic [31:0] exp_instr;
    logic [15:0] exp_mc;
    logic [31:0] exp_maddr;
  } vec_t;

  vec_t tbl [6];

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int n, es;
    logic [31:0] a;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0]  = 32'h00430800;
    mem[1]  = 32'h00A62001;
    mem[12] = 32'h1800FFF3;
    mdl_clear();
    mdl_mc    = 0;
    mdl_maddr = 32'd0;

    rst = 1'b1; pc_req = 1'b0; flush = 1'b0; pc_addr = 32'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset instr", instr, 32'd0);
    chk("reset valid", {31'd0, instr_valid}, 32'd0);
    chk("reset stall", {31'd0, stall}, 32'd0);
    chk("reset mem_addr", mem_addr, 32'd0);
    chk("reset miss_count", {16'd0, miss_count}, 32'd0);

    // Directed vectors: cold miss, same-line hit, other index, conflict
    tbl[0] = '{32'h00000000, 8, 32'h00430800, 16'd1, 32'h00000000};
    tbl[1] = '{32'h00000004, 0, 32'h00A62001, 16'd1, 32'h00000000};
    tbl[2] = '{32'h00000030, 8, 32'h1800FFF3, 16'd2, 32'h00000030};
    tbl[3] = '{32'h00000000, 0, 32'h00430800, 16'd2, 32'h00000030};
    tbl[4] = '{32'h00000080, 8, mem[32],      16'd3, 32'h00000080};
    tbl[5] = '{32'h00000000, 8, 32'h00430800, 16'd4, 32'h00000000};
    for (int i = 0; i < 6; i++) begin
      run_req(tbl[i].addr, n);
      mdl_access(tbl[i].addr, es);
      chk($sformatf("vec%0d stalls", i), n, tbl[i].exp_stalls);
      chk($sformatf("vec%0d valid", i), {31'd0, instr_valid}, 32'd1);
      chk($sformatf("vec%0d instr", i), instr, tbl[i].exp_instr);
      chk($sformatf("vec%0d miss_count", i), {16'd0, miss_count}, {16'd0, tbl[i].exp_mc});
      chk($sformatf("vec%0d mem_addr", i), mem_addr, tbl[i].exp_maddr);
    end

    // Flush in the third FETCH cycle: no fill, held request re-misses
    @(posedge clk); #1; pc_addr = 32'h00000100; pc_req = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk); #1; flush = 1'b1;
    @(negedge clk);
    chk("flush stall", {31'd0, stall}, 32'd1);
    chk("flush valid", {31'd0, instr_valid}, 32'd0);
    @(posedge clk); #1; flush = 1'b0;
    @(negedge clk);
    chk("flush mem_addr held", mem_addr, 32'h00000100);
    wait_serve(n);
    mdl_clear();
    mdl_mc++;
    mdl_access(32'h00000100, es);
    chk("reflush stalls", n, 8);
    chk("reflush instr", instr, mem[64]);
    chk("reflush miss_count", {16'd0, miss_count}, mdl_mc & 32'hFFFF);
    run_req(32'h00000030, n);
    mdl_access(32'h00000030, es);
    chk("post-flush 0x30 stalls", n, 8);
    chk("post-flush 0x30 instr", instr, 32'h1800FFF3);

    // Address changed mid-FETCH: latched line fills, new address misses after
    @(posedge clk); #1; pc_addr = 32'h00000040; pc_req = 1'b1;
    @(posedge clk);
    @(posedge clk); #1; pc_addr = 32'h00000050;
    @(negedge clk);
    wait_serve(n);
    mdl_access(32'h00000040, es);
    mdl_access(32'h00000050, es);
    chk("pc change stalls", n, 14);
    chk("pc change instr", instr, mem[20]);
    chk("pc change miss_count", {16'd0, miss_count}, mdl_mc & 32'hFFFF);
    check_req("latched 0x40", 32'h00000040);

    // Randomized requests against the model
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk); #1; pc_req = 1'b0;
        @(negedge clk);
        chk("idle valid", {31'd0, instr_valid}, 32'd0);
        chk("idle stall", {31'd0, stall}, 32'd0);
        chk("idle instr", instr, 32'd0);
      end
      a = $urandom & 32'h800003FF;
      check_req("rand", a);
    end

    // Asynchronous reset between edges in the middle of FETCH
    @(posedge clk); #1; pc_addr = 32'h00000200; pc_req = 1'b1;
    mdl_access(32'h00000200, es);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("pre-reset stall", {31'd0, stall}, 32'd1);
    #2; rst = 1'b1;
    #1;
    chk("async rst stall", {31'd0, stall}, 32'd0);
    chk("async rst valid", {31'd0, instr_valid}, 32'd0);
    chk("async rst instr", instr, 32'd0);
    chk("async rst mem_addr", mem_addr, 32'd0);
    chk("async rst miss_count", {16'd0, miss_count}, 32'd0);
    pc_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    mdl_clear();
    mdl_mc    = 0;
    mdl_maddr = 32'd0;
    check_req("after rst 0x0", 32'h00000000);
    check_req("after rst 0x4", 32'h00000004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
